// File: rtl/disp_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Digit 0 is the rightmost digit; nibble i of a packed word belongs to digit i.
package disp_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Digit 0 drives the rightmost display position.
    localparam bit DIGIT0_RIGHTMOST = 1'b1;

    // Active-low {dp,g,f,e,d,c,b,a}, dp off; leftmost entry is 4'hF.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef struct packed {
        logic [3:0] hex;
        logic       point;
        logic       blank;
        logic       blink;
    } digit_cfg_t;

    function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
        return SEG_TABLE[nib][6:0];
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} decode.
module seg_decode
    import disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg7(nib_i);

endmodule

// File: rtl/disp_scan_n.sv
// N-digit multiplexed 7-segment scan controller with double-buffered display
// word, per-digit blink, leading-zero suppression and anti-ghost blanking.
module disp_scan_n
    import disp_pkg::*;
#(
    parameter  int N_DIGITS    = 8,
    parameter  int SCAN_DIV_W  = 17,
    parameter  int BLINK_DIV_W = 25,
    localparam int IDX_W       = $clog2(N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] hexs,
    input  logic [N_DIGITS-1:0]   points,
    input  logic [N_DIGITS-1:0]   les,
    input  logic [N_DIGITS-1:0]   blink,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [3:0]            hex,
    output logic                  p,
    output logic                  le,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            seg,
    output logic                  frame_tick
);

    logic [SCAN_DIV_W-1:0]       presc_q, presc_d;
    logic [BLINK_DIV_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                        phase_off_q, phase_off_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        frame_tick_q, frame_tick_d;
    digit_cfg_t [N_DIGITS-1:0]   stage_q, stage_d;
    digit_cfg_t [N_DIGITS-1:0]   shadow_q, shadow_d;
    logic                        pending_q, pending_d;

    logic [3:0]                  hex_q, hex_d;
    logic                        p_q, p_d;
    logic                        le_q, le_d;
    logic [N_DIGITS-1:0]         an_q, an_d;
    logic [7:0]                  seg_q, seg_d;

    logic                        slot_tick;
    logic                        last_idx;
    logic                        wrap;
    logic                        first_clk;
    digit_cfg_t [N_DIGITS-1:0]   in_cfg;
    logic [N_DIGITS-1:0]         lz_mask;
    logic                        zero_run;
    digit_cfg_t                  cur;
    logic                        blank_cur;
    logic [6:0]                  seg7;
    logic [N_DIGITS-1:0]         an_onecold;

    assign slot_tick = &presc_q;
    assign last_idx  = (idx_q == IDX_W'(N_DIGITS - 1));
    assign wrap      = slot_tick & last_idx;
    assign first_clk = (presc_q == '0);

    always_comb begin
        in_cfg = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            in_cfg[i] = {hexs[4*i +: 4], points[i], les[i], blink[i]};
        end
    end

    // Walk down from the top digit; digit 0 is never part of the zero run.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & (shadow_q[i].hex == 4'h0);
            lz_mask[i] = lz_en & zero_run;
        end
    end

    assign cur        = shadow_q[idx_q];
    assign blank_cur  = cur.blank | lz_mask[idx_q] | (cur.blink & phase_off_q);
    assign an_onecold = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q);

    seg_decode u_seg_decode (
        .nib_i (cur.hex),
        .seg_o (seg7)
    );

    always_comb begin
        presc_d      = presc_q + SCAN_DIV_W'(1);
        blink_cnt_d  = blink_cnt_q + BLINK_DIV_W'(1);
        phase_off_d  = (&blink_cnt_q) ? ~phase_off_q : phase_off_q;
        idx_d        = idx_q;
        if (slot_tick) begin
            idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
        end
        frame_tick_d = wrap;

        // A load coinciding with the wrap lands in staging while the old
        // staging commits, so pending stays set for the following frame.
        shadow_d  = shadow_q;
        stage_d   = stage_q;
        pending_d = pending_q;
        if (wrap && pending_q) begin
            shadow_d  = stage_q;
            pending_d = 1'b0;
        end
        if (load) begin
            stage_d   = in_cfg;
            pending_d = 1'b1;
        end

        hex_d = cur.hex;
        p_d   = cur.point;
        le_d  = blank_cur;
        an_d  = (blank_cur || first_clk) ? '1 : an_onecold;
        seg_d = blank_cur ? SEG_BLANK : {~cur.point, seg7};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            blink_cnt_q  <= '0;
            phase_off_q  <= 1'b0;
            idx_q        <= '0;
            frame_tick_q <= 1'b0;
            stage_q      <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            hex_q        <= 4'h0;
            p_q          <= 1'b0;
            le_q         <= 1'b1;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
        end else begin
            presc_q      <= presc_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_off_q  <= phase_off_d;
            idx_q        <= idx_d;
            frame_tick_q <= frame_tick_d;
            stage_q      <= stage_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            hex_q        <= hex_d;
            p_q          <= p_d;
            le_q         <= le_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign hex        = hex_q;
    assign p          = p_q;
    assign le         = le_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_n.sv
// Self-checking bench for disp_scan_n: directed scenarios plus random traffic,
// compared every cycle against a time-indexed behavioural model.
module tb_disp_scan_n;

    localparam int N = 8;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic [31:0] hexs   = '0;
    logic [7:0]  points = '0;
    logic [7:0]  les    = '0;
    logic [7:0]  blink  = '0;
    logic        lz_en  = 1'b0;
    logic        load   = 1'b0;

    logic [3:0]  hex;
    logic        p;
    logic        le;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;

    always #5 clk = ~clk;

    disp_scan_n #(
        .N_DIGITS    (N),
        .SCAN_DIV_W  (2),
        .BLINK_DIV_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hexs       (hexs),
        .points     (points),
        .les        (les),
        .blink      (blink),
        .lz_en      (lz_en),
        .load       (load),
        .hex        (hex),
        .p          (p),
        .le         (le),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    int tests = 0;
    int fails = 0;

    // Model: k = clocks since reset; slot = k/4, digit = slot%8, phase = (k/16)%2.
    int          k = 0;
    logic [31:0] st_hex = '0, sh_hex = '0;
    logic [7:0]  st_pt = '0, st_le = '0, st_bl = '0;
    logic [7:0]  sh_pt = '0, sh_le = '0, sh_bl = '0;
    bit          pend = 1'b0;

    logic [7:0] segt [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic int msd(input logic [31:0] h);
        for (int i = N - 1; i >= 1; i--) begin
            if (h[4*i +: 4] != 4'h0) return i;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        logic [7:0] e_an, e_seg;
        logic [3:0] e_hex;
        logic       e_p, e_le, e_ft;
        int         d;
        bit         blank;
        if (rst) begin
            e_an = 8'hFF; e_seg = 8'hFF; e_hex = 4'h0; e_p = 1'b0; e_le = 1'b1; e_ft = 1'b0;
            k = 0; pend = 1'b0;
            st_hex = '0; st_pt = '0; st_le = '0; st_bl = '0;
            sh_hex = '0; sh_pt = '0; sh_le = '0; sh_bl = '0;
        end else begin
            d     = (k / 4) % N;
            blank = sh_le[d] || (lz_en && d > msd(sh_hex)) || (sh_bl[d] && ((k / 16) % 2 == 1));
            e_hex = sh_hex[4*d +: 4];
            e_p   = sh_pt[d];
            e_le  = blank;
            e_an  = (blank || (k % 4 == 0)) ? 8'hFF : ~(8'h01 << d);
            e_seg = blank ? 8'hFF : {~e_p, segt[e_hex][6:0]};
            e_ft  = (k % 32 == 31);
            if (k % 32 == 31 && pend) begin
                sh_hex = st_hex; sh_pt = st_pt; sh_le = st_le; sh_bl = st_bl;
                pend   = 1'b0;
            end
            if (load) begin
                st_hex = hexs; st_pt = points; st_le = les; st_bl = blink;
                pend   = 1'b1;
            end
            k++;
        end
        @(posedge clk);
        #1;
        check("an",         32'(an),         32'(e_an));
        check("seg",        32'(seg),        32'(e_seg));
        check("hex",        32'(hex),        32'(e_hex));
        check("p",          32'(p),          32'(e_p));
        check("le",         32'(le),         32'(e_le));
        check("frame_tick", 32'(frame_tick), 32'(e_ft));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [31:0] h);
        hexs = h; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run(2);
        rst = 1'b0;

        // Plain digits, frame ticks every 32 clocks.
        do_load(32'h12345678);
        run(80);

        // Leading-zero suppression, then all-zero word.
        lz_en = 1'b1;
        do_load(32'h00000450);
        run(70);
        do_load(32'h00000000);
        run(70);

        // Mid-frame load at digit 3, then load on the wrap cycle.
        do_load(32'h12345678);
        run(40);
        for (int g = 0; g < 64 && ((k / 4) % N) != 3; g++) step();
        do_load(32'hAAAAAAAA);
        run(70);
        for (int g = 0; g < 64 && (k % 32) != 31; g++) step();
        do_load($urandom);
        run(70);

        // Blink and point on digit 0.
        lz_en = 1'b0; blink = 8'h01; points = 8'h01;
        do_load($urandom);
        run(80);

        // Reset at digit 5 with a load pending.
        blink = 8'h00; points = 8'h00;
        do_load(32'h99999999);
        run(40);
        do_load(32'h55555555);
        for (int g = 0; g < 64 && ((k / 4) % N) != 5; g++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(70);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            load = ($urandom_range(0, 7) == 0);
            if (load) begin
                hexs   = $urandom;
                points = 8'($urandom);
                les    = 8'($urandom & $urandom & $urandom);
                blink  = 8'($urandom & $urandom);
            end
            if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        load = 1'b0;
        rst  = 1'b0;
        run(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
